lcd_hd44780_driver: RTL

- Physical-layer driver for the HD44780-compatible character LCD in 4-bit mode. It sits directly downstream of the register-display formatter inside cpu_lcd_system.
- Accepts byte writes (RS + 8-bit data) over a valid/ready handshake.
- Runs the mandatory power-on initialisation on its own after reset.
- Splits each byte into high and low nibbles and generates RS/EN/D[7:4] timing with correct execution-time waits.
- Produces lcd_rs, lcd_rw, lcd_en, lcd_data and the ready status consumed by top-level debug.

---
 rtl/lcd_hd44780_driver.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_hd44780_driver.sv
// HD44780 4-bit physical-layer driver: power-on init, then byte writes as
// two EN-strobed nibbles followed by an execution-time wait.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// PWRUP    | counting the power-up delay after reset release
// IDLE     | initialised, cmd_ready high, waiting for a byte
// SEND_HI  | nibble sub-sequence (SETUP/EN_HI/EN_LO) for data[7:4]
// SEND_LO  | nibble sub-sequence for data[3:0] (also single-nibble init steps)
// WAIT     | execution-time wait after a byte or init step
//
// Init progress is tracked by step_q while init_done is low; the next step is
// launched directly from WAIT, so no extra cycle is spent between steps.
// Each operation starts one cycle after its launch edge (outputs are
// registered), so the post-byte wait counts one cycle less to keep the busy
// window at exactly 2*(SETUP+EN_HIGH+GAP) + wait cycles.
module lcd_hd44780_driver #(
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned EN_HIGH_CYC   = 27,
    parameter int unsigned GAP_CYC       = 27,
    parameter int unsigned EXEC_CYC      = 1080,
    parameter int unsigned LONG_EXEC_CYC = 44280,
    parameter int unsigned POWERUP_CYC   = 405000,
    parameter int unsigned INIT_W1_CYC   = 110700,
    parameter int unsigned INIT_W2_CYC   = 2700
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [3:0] lcd_data
);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, EN_HIGH_CYC), max_u(GAP_CYC, EXEC_CYC)),
                                            max_u(max_u(LONG_EXEC_CYC, POWERUP_CYC), max_u(INIT_W1_CYC, INIT_W2_CYC)));
    localparam int CNT_W = $clog2(MAX_CYC) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t C_SETUP    = cnt_t'(SETUP_CYC);
    localparam cnt_t C_SETUP_M1 = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t C_ENH_M1   = cnt_t'(EN_HIGH_CYC - 1);
    localparam cnt_t C_GAP_M1   = cnt_t'(GAP_CYC - 1);
    localparam cnt_t C_PWR_M1   = cnt_t'(POWERUP_CYC - 1);
    localparam cnt_t C_EXEC     = cnt_t'(EXEC_CYC);
    localparam cnt_t C_LONG     = cnt_t'(LONG_EXEC_CYC);
    localparam cnt_t C_W1       = cnt_t'(INIT_W1_CYC);
    localparam cnt_t C_W2       = cnt_t'(INIT_W2_CYC);
    localparam cnt_t C_TWO      = cnt_t'(2);

    typedef enum logic [2:0] {
        ST_PWRUP, ST_IDLE, ST_SEND_HI, ST_SEND_LO, ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP, PH_EN_HI, PH_EN_LO
    } phase_t;

    state_t     state_q;
    phase_t     phase_q;
    cnt_t       cnt_q;
    cnt_t       wait_q;
    logic [2:0] step_q;
    logic [7:0] byte_q;
    logic       rs_q;
    logic       cmd_ready_q;
    logic       init_done_q;
    logic       lcd_rs_q;
    logic       lcd_en_q;
    logic [3:0] lcd_data_q;

    logic [2:0] rom_idx_d;
    logic [7:0] rom_byte_d;
    logic       rom_nib_d;
    cnt_t       rom_wait_d;
    cnt_t       cmd_wait_d;

    // Clear and return-home need the long execution time.
    function automatic cnt_t byte_wait(input logic rs, input logic [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03))
            return C_LONG;
        return C_EXEC;
    endfunction

    assign rom_idx_d  = (state_q == ST_PWRUP) ? 3'd0 : step_q + 3'd1;
    assign cmd_wait_d = byte_wait(cmd_rs, cmd_data);

    // Init step ROM: four single-nibble wake-up steps, then four full instructions.
    always_comb begin
        rom_byte_d = 8'h00;
        rom_nib_d  = 1'b0;
        rom_wait_d = C_EXEC;
        case (rom_idx_d)
            3'd0: begin rom_byte_d = 8'h03; rom_nib_d = 1'b1; rom_wait_d = C_W1;   end
            3'd1: begin rom_byte_d = 8'h03; rom_nib_d = 1'b1; rom_wait_d = C_W2;   end
            3'd2: begin rom_byte_d = 8'h03; rom_nib_d = 1'b1; rom_wait_d = C_EXEC; end
            3'd3: begin rom_byte_d = 8'h02; rom_nib_d = 1'b1; rom_wait_d = C_EXEC; end
            3'd4: rom_byte_d = 8'h28;
            3'd5: rom_byte_d = 8'h0C;
            3'd6: rom_byte_d = 8'h01;
            default: rom_byte_d = 8'h06;
        endcase
        if (!rom_nib_d)
            rom_wait_d = byte_wait(1'b0, rom_byte_d);
    end

    // Main sequencer: power-up, init steps, nibble strobes and waits, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWRUP;
            phase_q     <= PH_SETUP;
            cnt_q       <= '0;
            wait_q      <= '0;
            step_q      <= '0;
            byte_q      <= '0;
            rs_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_data_q  <= '0;
        end else begin
            case (state_q)
                ST_PWRUP, ST_WAIT: begin
                    if ((state_q == ST_PWRUP && cnt_q == C_PWR_M1) ||
                        (state_q == ST_WAIT && cnt_q == '0 && !init_done_q && step_q != 3'd7)) begin
                        step_q  <= rom_idx_d;
                        byte_q  <= rom_byte_d;
                        rs_q    <= 1'b0;
                        wait_q  <= rom_wait_d;
                        state_q <= rom_nib_d ? ST_SEND_LO : ST_SEND_HI;
                        phase_q <= PH_SETUP;
                        cnt_q   <= C_SETUP;
                    end else if (state_q == ST_WAIT && cnt_q == '0) begin
                        init_done_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (state_q == ST_PWRUP) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        byte_q      <= cmd_data;
                        rs_q        <= cmd_rs;
                        wait_q      <= cmd_wait_d;
                        state_q     <= ST_SEND_HI;
                        phase_q     <= PH_SETUP;
                        cnt_q       <= C_SETUP;
                        cmd_ready_q <= 1'b0;
                    end
                end
                ST_SEND_HI, ST_SEND_LO: begin
                    case (phase_q)
                        PH_SETUP: begin
                            lcd_rs_q   <= rs_q;
                            lcd_data_q <= (state_q == ST_SEND_HI) ? byte_q[7:4] : byte_q[3:0];
                            if (cnt_q == '0) begin
                                lcd_en_q <= 1'b1;
                                phase_q  <= PH_EN_HI;
                                cnt_q    <= C_ENH_M1;
                            end else begin
                                cnt_q <= cnt_q - 1'b1;
                            end
                        end
                        PH_EN_HI: begin
                            if (cnt_q == '0) begin
                                lcd_en_q <= 1'b0;
                                phase_q  <= PH_EN_LO;
                                cnt_q    <= C_GAP_M1;
                            end else begin
                                cnt_q <= cnt_q - 1'b1;
                            end
                        end
                        default: begin
                            if (cnt_q != '0) begin
                                cnt_q <= cnt_q - 1'b1;
                            end else if (state_q == ST_SEND_HI) begin
                                state_q    <= ST_SEND_LO;
                                phase_q    <= PH_SETUP;
                                lcd_data_q <= byte_q[3:0];
                                cnt_q      <= C_SETUP_M1;
                            end else begin
                                state_q <= ST_WAIT;
                                cnt_q   <= wait_q - C_TWO;
                            end
                        end
                    endcase
                end
                default: state_q <= ST_PWRUP;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign init_done = init_done_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = lcd_en_q;
    assign lcd_data  = lcd_data_q;

endmodule
